// File: rtl/rtc_alarm.sv
// Real-time clock with prescaled 1 Hz tick, range-checked load, 12/24-hour display,
// one-shot alarm compare and day-rollover pulse. Single clock, synchronous reset.
module rtc_alarm #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] load_hrs,
  input  logic [5:0] load_mins,
  input  logic [5:0] load_sec,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hrs,
  input  logic [5:0] alarm_mins,
  input  logic       alarm_en,
  input  logic       mode_12h,
  output logic [4:0] hrs,
  output logic [5:0] mins,
  output logic [5:0] sec,
  output logic       pm,
  output logic       tick_1hz,
  output logic       day_tick,
  output logic       alarm,
  output logic       load_err
);

  localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(PRESCALE - 1);

  logic [PrescW-1:0] presc_q, presc_d;
  logic [4:0]        hrs_q, hrs_d;
  logic [5:0]        min_q, min_d;
  logic [5:0]        sec_q, sec_d;
  logic [4:0]        alm_hrs_q, alm_hrs_d;
  logic [5:0]        alm_min_q, alm_min_d;
  logic              tick_q, tick_d;
  logic              day_q, day_d;
  logic              alarm_q, alarm_d;
  logic              err_q, err_d;

  logic       tick_now;
  logic       load_ok;
  logic       aset_ok;
  logic       advance;
  logic [4:0] hrs_inc;
  logic [5:0] min_inc;
  logic [5:0] sec_inc;
  logic       rollover;
  logic [4:0] hrs_mod;

  assign tick_now = en && (presc_q == PrescMax);
  assign load_ok  = load && (load_hrs <= 5'd23) && (load_mins <= 6'd59) && (load_sec <= 6'd59);
  assign aset_ok  = alarm_set && (alarm_hrs <= 5'd23) && (alarm_mins <= 6'd59);
  // A valid load wins over a coincident tick; an invalid one lets the tick through.
  assign advance  = tick_now && !load_ok;
  assign rollover = (hrs_q == 5'd23) && (min_q == 6'd59) && (sec_q == 6'd59);

  // Time value one second ahead of the current registers, with carries.
  always_comb begin
    sec_inc = sec_q + 6'd1;
    min_inc = min_q;
    hrs_inc = hrs_q;
    if (sec_q == 6'd59) begin
      sec_inc = 6'd0;
      min_inc = min_q + 6'd1;
      if (min_q == 6'd59) begin
        min_inc = 6'd0;
        hrs_inc = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
      end
    end
  end

  // Next-state for prescaler, time, alarm registers and pulse outputs.
  always_comb begin
    presc_d   = presc_q;
    hrs_d     = hrs_q;
    min_d     = min_q;
    sec_d     = sec_q;
    alm_hrs_d = alm_hrs_q;
    alm_min_d = alm_min_q;

    if (load_ok) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = (presc_q == PrescMax) ? '0 : presc_q + 1'b1;
    end

    if (load_ok) begin
      hrs_d = load_hrs;
      min_d = load_mins;
      sec_d = load_sec;
    end else if (advance) begin
      hrs_d = hrs_inc;
      min_d = min_inc;
      sec_d = sec_inc;
    end

    if (aset_ok) begin
      alm_hrs_d = alarm_hrs;
      alm_min_d = alarm_mins;
    end

    tick_d  = advance;
    day_d   = advance && rollover;
    alarm_d = advance && alarm_en && (sec_inc == 6'd0) &&
              (min_inc == alm_min_q) && (hrs_inc == alm_hrs_q);
    // Rejected load and rejected alarm_set share one pulse.
    err_d   = (load && !load_ok) || (alarm_set && !aset_ok);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      hrs_q     <= 5'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      alm_hrs_q <= 5'd0;
      alm_min_q <= 6'd0;
      tick_q    <= 1'b0;
      day_q     <= 1'b0;
      alarm_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      hrs_q     <= hrs_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      alm_hrs_q <= alm_hrs_d;
      alm_min_q <= alm_min_d;
      tick_q    <= tick_d;
      day_q     <= day_d;
      alarm_q   <= alarm_d;
      err_q     <= err_d;
    end
  end

  // Display decode: combinational so a mode change shows up immediately.
  always_comb begin
    hrs     = hrs_q;
    pm      = 1'b0;
    hrs_mod = hrs_q;
    if (mode_12h) begin
      if (hrs_q >= 5'd12) begin
        pm      = 1'b1;
        hrs_mod = hrs_q - 5'd12;
      end
      hrs = (hrs_mod == 5'd0) ? 5'd12 : hrs_mod;
    end
  end

  assign mins     = min_q;
  assign sec      = sec_q;
  assign tick_1hz = tick_q;
  assign day_tick = day_q;
  assign alarm    = alarm_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_rtc_alarm.sv
// Scoreboard bench for rtc_alarm with PRESCALE=4: the driver pushes the expected outputs
// for each upcoming edge; the monitor pops and compares just after that edge.
module tb_rtc_alarm;

  logic       clk;
  logic       reset, en, load, alarm_set, alarm_en, mode_12h;
  logic [4:0] load_hrs, alarm_hrs;
  logic [5:0] load_mins, load_sec, alarm_mins;
  logic [4:0] hrs;
  logic [5:0] mins, sec;
  logic       pm, tick_1hz, day_tick, alarm, load_err;

  typedef struct {
    string      nm;
    int         cyc;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       pm;
    logic       tk;
    logic       dy;
    logic       al;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int   cyc_n    = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stop_req = 1'b0;

  rtc_alarm #(.PRESCALE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .load_hrs   (load_hrs),
    .load_mins  (load_mins),
    .load_sec   (load_sec),
    .alarm_set  (alarm_set),
    .alarm_hrs  (alarm_hrs),
    .alarm_mins (alarm_mins),
    .alarm_en   (alarm_en),
    .mode_12h   (mode_12h),
    .hrs        (hrs),
    .mins       (mins),
    .sec        (sec),
    .pm         (pm),
    .tick_1hz   (tick_1hz),
    .day_tick   (day_tick),
    .alarm      (alarm),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, want end within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  // Expected outputs after the next rising edge; then advance to the following negedge.
  task automatic chk(input string nm, input int h, input int m, input int s, input bit epm,
                     input bit tk, input bit dy, input bit al, input bit er);
    exp_t e;
    e.nm  = nm;
    e.cyc = cyc_n + 1;
    e.h   = 5'(h);
    e.m   = 6'(m);
    e.s   = 6'(s);
    e.pm  = epm;
    e.tk  = tk;
    e.dy  = dy;
    e.al  = al;
    e.er  = er;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic ldset(input int h, input int m, input int s);
    load      = 1'b1;
    load_hrs  = 5'(h);
    load_mins = 6'(m);
    load_sec  = 6'(s);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    exp_t       e;
    logic [21:0] act, want;
    forever begin
      @(posedge clk);
      cyc_n++;
      #1;
      if (stop_req) begin
        n_checks++;
        if (sb.size() != 0) begin
          n_errors++;
          $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
      while (sb.size() != 0 && sb[0].cyc <= cyc_n) begin
        e = sb.pop_front();
        n_checks++;
        act  = {hrs, mins, sec, pm, tick_1hz, day_tick, alarm, load_err};
        want = {e.h, e.m, e.s, e.pm, e.tk, e.dy, e.al, e.er};
        if (e.cyc != cyc_n || act !== want) begin
          n_errors++;
          $display("FAIL %s cyc %0d (exp cyc %0d): got %0d:%0d:%0d pm=%b tick=%b day=%b alarm=%b err=%b, want %0d:%0d:%0d pm=%b tick=%b day=%b alarm=%b err=%b",
                   e.nm, cyc_n, e.cyc, hrs, mins, sec, pm, tick_1hz, day_tick, alarm, load_err,
                   e.h, e.m, e.s, e.pm, e.tk, e.dy, e.al, e.er);
        end
      end
    end
  end

  initial begin : driver
    int hs[5]  = '{0, 11, 12, 13, 23};
    int h12[5] = '{12, 11, 12, 1, 11};
    bit p12[5] = '{0, 0, 1, 1, 1};

    reset = 1'b1; en = 1'b0; load = 1'b0; alarm_set = 1'b0; alarm_en = 1'b0;
    mode_12h = 1'b0; load_hrs = '0; load_mins = '0; load_sec = '0;
    alarm_hrs = '0; alarm_mins = '0;

    // 1: reset, then free run; tick every 4th edge
    chk("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; en = 1'b1;
    for (int i = 1; i <= 12; i++) chk("run", 0, 0, i / 4, 0, (i % 4) == 0, 0, 0, 0);

    // 2: day rollover
    ldset(23, 59, 58);
    chk("load_235958", 23, 59, 58, 0, 0, 0, 0, 0);
    load = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (j < 4)      chk("pre_roll", 23, 59, 58, 0, 0, 0, 0, 0);
      else if (j < 8) chk("last_sec", 23, 59, 59, 0, j == 4, 0, 0, 0);
      else            chk("rollover", 0, 0, 0, 0, 1, 1, 0, 0);
    end

    // 3: range checking and load priority (prescaler now 0)
    ldset(24, 0, 0);
    chk("bad_hrs", 0, 0, 0, 0, 0, 0, 0, 1);
    ldset(10, 60, 0);
    chk("bad_mins", 0, 0, 0, 0, 0, 0, 0, 1);
    load = 1'b0;
    chk("err_clear", 0, 0, 0, 0, 0, 0, 0, 0);
    ldset(10, 0, 0);
    chk("load_on_tick", 10, 0, 0, 0, 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) chk("presc_restart", 10, 0, 0, 0, 0, 0, 0, 0);
    chk("tick_after_load", 10, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) chk("idle", 10, 0, 1, 0, 0, 0, 0, 0);
    ldset(24, 0, 0);
    chk("bad_load_on_tick", 10, 0, 2, 0, 1, 0, 0, 1);
    ldset(25, 0, 0);
    alarm_set = 1'b1; alarm_hrs = 5'd24; alarm_mins = 6'd0;
    chk("both_bad", 10, 0, 2, 0, 0, 0, 0, 1);
    load = 1'b0; alarm_set = 1'b0;
    chk("both_bad_once", 10, 0, 2, 0, 0, 0, 0, 0);
    alarm_set = 1'b1; alarm_hrs = 5'd7; alarm_mins = 6'd60;
    chk("bad_alarm", 10, 0, 2, 0, 0, 0, 0, 1);
    alarm_set = 1'b0;
    chk("tick_10_00_03", 10, 0, 3, 0, 1, 0, 0, 0);

    // 4: alarm
    alarm_set = 1'b1; alarm_hrs = 5'd7; alarm_mins = 6'd30; alarm_en = 1'b1;
    chk("alarm_set", 10, 0, 3, 0, 0, 0, 0, 0);
    alarm_set = 1'b0;
    ldset(7, 29, 59);
    chk("load_072959", 7, 29, 59, 0, 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) chk("pre_alarm", 7, 29, 59, 0, 0, 0, 0, 0);
    chk("alarm_fire", 7, 30, 0, 0, 1, 0, 1, 0);
    chk("alarm_one_cycle", 7, 30, 0, 0, 0, 0, 0, 0);
    alarm_en = 1'b0;
    ldset(7, 29, 59);
    chk("reload_072959", 7, 29, 59, 0, 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) chk("pre_alarm_off", 7, 29, 59, 0, 0, 0, 0, 0);
    chk("alarm_disabled", 7, 30, 0, 0, 1, 0, 0, 0);
    alarm_en = 1'b1;
    for (int i = 1; i <= 3; i++) chk("hold_0730", 7, 30, 0, 0, 0, 0, 0, 0);
    ldset(7, 30, 0);
    chk("load_to_alarm", 7, 30, 0, 0, 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) chk("post_load", 7, 30, 0, 0, 0, 0, 0, 0);
    chk("no_alarm_at_01", 7, 30, 1, 0, 1, 0, 0, 0);
    alarm_en = 1'b0;

    // 5: 12/24-hour display with time frozen
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mode_12h = 1'b1;
      ldset(hs[k], 0, 0);
      chk("disp_12h", h12[k], 0, 0, p12[k], 0, 0, 0, 0);
      load = 1'b0; mode_12h = 1'b0;
      chk("disp_24h", hs[k], 0, 0, 0, 0, 0, 0, 0);
    end

    // 6: enable freeze, then reset during a load
    en = 1'b1;
    ldset(12, 34, 56);
    chk("load_123456", 12, 34, 56, 0, 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 1; i <= 2; i++) chk("count", 12, 34, 56, 0, 0, 0, 0, 0);
    en = 1'b0;
    for (int i = 1; i <= 10; i++) chk("frozen", 12, 34, 56, 0, 0, 0, 0, 0);
    en = 1'b1;
    chk("resume", 12, 34, 56, 0, 0, 0, 0, 0);
    chk("resume_tick", 12, 34, 57, 0, 1, 0, 0, 0);
    reset = 1'b1;
    ldset(30, 0, 0);
    chk("reset_over_load", 0, 0, 0, 0, 0, 0, 0, 0);
    load = 1'b0; reset = 1'b0; alarm_en = 1'b1;
    ldset(23, 59, 59);
    chk("load_235959", 23, 59, 59, 0, 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) chk("pre_midnight", 23, 59, 59, 0, 0, 0, 0, 0);
    chk("midnight_alarm", 0, 0, 0, 0, 1, 1, 1, 0);

    stop_req = 1'b1;
  end

endmodule
